// File: rtl/pkg_convolution.sv
// Shared configuration for the convolution units: kernel/array sizes per unit,
// common widths and the sequencer state type.
package pkg_convolution;

  localparam int unsigned CONVUNITS     = 2;
  localparam int unsigned ACT_BITS      = 3;
  localparam int unsigned CONV_SIZE_MAX = 31;

  localparam int unsigned KER_SIZE  [CONVUNITS] = '{5, 3};
  localparam int unsigned CONV_SIZE [CONVUNITS] = '{31, 16};

  localparam int unsigned ROWS_W = $clog2(CONV_SIZE_MAX + 1);
  localparam int unsigned ROW_W  = $clog2(CONV_SIZE_MAX);
  localparam int unsigned BIT_W  = $clog2(ACT_BITS);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } conv_state_e;

  // Kernel-row index width; a 1x1 kernel still needs a 1-bit field.
  function automatic int unsigned krow_w(int unsigned ks);
    return (ks > 1) ? $clog2(ks) : 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Command, memory-ready and issue/result signals between a sequencer and its
// controller / convolution unit.
interface conv_sequencer_if
  import pkg_convolution::*;
#(
  parameter int unsigned UNIT = 0
);

  localparam int unsigned KrowW = krow_w(KER_SIZE[UNIT]);

  logic              start;
  logic [ROWS_W-1:0] rows;
  logic              abort;
  logic              mem_ready;
  logic              busy;
  logic              conv_en;
  logic              conv_clear;
  logic [ROW_W-1:0]  conv_row;
  logic [KrowW-1:0]  conv_krow;
  logic [BIT_W-1:0]  conv_bit;
  logic              out_valid;
  logic [ROW_W-1:0]  out_row;
  logic              done;

  modport slave (
    input  start, rows, abort, mem_ready,
    output busy, conv_en, conv_clear, conv_row, conv_krow, conv_bit,
           out_valid, out_row, done
  );

  modport master (
    output start, rows, abort, mem_ready,
    input  busy, conv_en, conv_clear, conv_row, conv_krow, conv_bit,
           out_valid, out_row, done
  );

endinterface

// File: rtl/conv_loop_counter.sv
// Nested loop counter: k (kernel row, innermost, up), b (bit plane, down from
// MSB), o (output row, outermost, up to o_last_i).
module conv_loop_counter #(
  parameter int unsigned KS       = 5,
  parameter int unsigned ACT_BITS = 3,
  parameter int unsigned KrowW    = 3,
  parameter int unsigned BitW     = 2,
  parameter int unsigned RowW     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_i,
  input  logic            step_i,
  input  logic [RowW-1:0] o_last_i,
  output logic [KrowW-1:0] k_o,
  output logic [BitW-1:0]  b_o,
  output logic [RowW-1:0]  o_o,
  output logic            k_wrap_o,
  output logic            b_wrap_o,
  output logic            last_o
);

  localparam logic [KrowW-1:0] KMax = KrowW'(KS - 1);
  localparam logic [BitW-1:0]  BMsb = BitW'(ACT_BITS - 1);

  logic [KrowW-1:0] k_q, k_d;
  logic [BitW-1:0]  b_q, b_d;
  logic [RowW-1:0]  o_q, o_d;

  // b_wrap marks the step that completes all bit planes of the current output row.
  assign k_wrap_o = (k_q == KMax);
  assign b_wrap_o = k_wrap_o && (b_q == '0);
  assign last_o   = b_wrap_o && (o_q == o_last_i);

  always_comb begin
    k_d = k_q;
    b_d = b_q;
    o_d = o_q;
    if (init_i) begin
      k_d = '0;
      b_d = BMsb;
      o_d = '0;
    end else if (step_i) begin
      if (!k_wrap_o) begin
        k_d = k_q + KrowW'(1);
      end else begin
        k_d = '0;
        if (b_q != '0) begin
          b_d = b_q - BitW'(1);
        end else begin
          b_d = BMsb;
          o_d = o_q + RowW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      b_q <= '0;
      o_q <= '0;
    end else begin
      k_q <= k_d;
      b_q <= b_d;
      o_q <= o_d;
    end
  end

  assign k_o = k_q;
  assign b_o = b_q;
  assign o_o = o_q;

endmodule

// File: rtl/conv_sequencer.sv
// Bit-serial convolution sequencer: walks kernel rows, activation bit planes and
// output rows, issuing one row read per ready cycle and flagging finished rows.
module conv_sequencer
  import pkg_convolution::*;
#(
  parameter int unsigned UNIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_sequencer_if.slave  bus
);

  localparam int unsigned KS    = KER_SIZE[UNIT];
  localparam int unsigned CS    = CONV_SIZE[UNIT];
  localparam int unsigned KrowW = krow_w(KS);

  localparam logic [ROWS_W-1:0] KsRows = ROWS_W'(KS);
  localparam logic [ROWS_W-1:0] CsRows = ROWS_W'(CS);
  localparam logic [BIT_W-1:0]  BMsb   = BIT_W'(ACT_BITS - 1);

  conv_state_e       state_q, state_d;
  logic [ROWS_W-1:0] r_q, r_d;
  logic              out_valid_q, out_valid_d;
  logic [ROW_W-1:0]  out_row_q, out_row_d;

  logic [ROWS_W-1:0] rows_clamped;
  logic [ROW_W-1:0]  o_last;
  logic              cnt_init;
  logic              issue;
  logic              k_wrap, b_wrap, cnt_last;
  logic [KrowW-1:0]  k;
  logic [BIT_W-1:0]  b;
  logic [ROW_W-1:0]  o;

  assign rows_clamped = (bus.rows > CsRows) ? CsRows : bus.rows;
  // Only consulted in ISSUE, where r_q >= KS holds.
  assign o_last       = ROW_W'(r_q - KsRows);
  assign issue        = (state_q == StIssue) && bus.mem_ready;

  conv_loop_counter #(
    .KS       (KS),
    .ACT_BITS (ACT_BITS),
    .KrowW    (KrowW),
    .BitW     (BIT_W),
    .RowW     (ROW_W)
  ) u_loop (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_i   (cnt_init),
    .step_i   (issue),
    .o_last_i (o_last),
    .k_o      (k),
    .b_o      (b),
    .o_o      (o),
    .k_wrap_o (k_wrap),
    .b_wrap_o (b_wrap),
    .last_o   (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    cnt_init    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          r_d      = rows_clamped;
          cnt_init = 1'b1;
          state_d  = (rows_clamped >= KsRows) ? StIssue : StDone;
        end
      end
      StIssue: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.mem_ready) begin
          if (b_wrap) begin
            out_valid_d = 1'b1;
            out_row_d   = o;
          end
          if (cnt_last) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
    end
  end

  // abort in DONE cancels the completion pulse and the last row's out_valid.
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone) && !bus.abort;
  assign bus.out_valid  = out_valid_q && !bus.abort;
  assign bus.out_row    = out_row_q;
  assign bus.conv_en    = issue;
  assign bus.conv_clear = issue && (k == '0) && (b == BMsb);
  assign bus.conv_row   = o + ROW_W'(k);
  assign bus.conv_krow  = k;
  assign bus.conv_bit   = b;

endmodule
